// File: rtl/pong_pkg.sv
// Shared Pong definitions: board geometry, match state encodings, winner codes
// and the paddle-miss test used by the match sequencer.
package pong_pkg;

    localparam int c_GAME_WIDTH    = 40;
    localparam int c_GAME_HEIGHT   = 30;
    localparam int c_PADDLE_HEIGHT = 6;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_RUNNING    = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Bottom paddle row is formed 7 bits wide so a paddle near row 63 cannot wrap.
    function automatic logic paddle_miss(input logic [5:0] ball_y,
                                         input logic [5:0] paddle_top,
                                         input int unsigned paddle_h);
        logic [6:0] top;
        logic [6:0] bottom;
        top    = {1'b0, paddle_top};
        bottom = top + 7'(paddle_h) - 7'd1;
        return ({1'b0, ball_y} < top) || ({1'b0, ball_y} > bottom);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] score);
        return (score == 4'd15) ? 4'd15 : score + 4'd1;
    endfunction

endpackage

// File: rtl/pong_edge_det.sv
// One-bit rising-edge detector: a single-cycle pulse per low-to-high transition.
module pong_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) prev_q <= 1'b0;
        else          prev_q <= sig_i;
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing on frame ticks, miss detection, scoring
// and winner selection. All outputs are registered from the next state.
//   state      | meaning
//   IDLE       | waiting for first start press, ball held at centre
//   SERVE_WAIT | counting frames before releasing the ball
//   RUNNING    | ball in play, watching both goal columns
//   POINT      | one cycle: award the point, check for match end
//   GAME_OVER  | final score and winner shown until next start press
module pong_match_ctrl #(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_SCORE_LIMIT   = 9,
    parameter int c_SERVE_FRAMES  = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VSync,
    input  logic       i_Game_Start,
    input  logic [5:0] i_Ball_X,
    input  logic [5:0] i_Ball_Y,
    input  logic [5:0] i_Paddle_Y_P1,
    input  logic [5:0] i_Paddle_Y_P2,
    output logic       o_Game_Active,
    output logic       o_Ball_Reset,
    output logic       o_Serve_Dir,
    output logic [3:0] o_P1_Score,
    output logic [3:0] o_P2_Score,
    output logic [1:0] o_Winner,
    output logic [2:0] o_State
);

    import pong_pkg::*;

    logic vsync_tick;
    logic start_tick;

    pong_edge_det u_vsync_edge (
        .clk_i   (i_Clk),
        .rst_n_i (i_Rst_L),
        .sig_i   (i_VSync),
        .rise_o  (vsync_tick)
    );

    pong_edge_det u_start_edge (
        .clk_i   (i_Clk),
        .rst_n_i (i_Rst_L),
        .sig_i   (i_Game_Start),
        .rise_o  (start_tick)
    );

    state_e     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic       serve_dir_q, serve_dir_d;
    logic [1:0] winner_q, winner_d;
    logic       game_active_q;
    logic       ball_reset_q;

    logic p1_miss;
    logic p2_miss;

    assign p1_miss = (i_Ball_X == 6'd0)
                   && paddle_miss(i_Ball_Y, i_Paddle_Y_P1, c_PADDLE_HEIGHT);
    assign p2_miss = (i_Ball_X == 6'(c_GAME_WIDTH - 1))
                   && paddle_miss(i_Ball_Y, i_Paddle_Y_P2, c_PADDLE_HEIGHT);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (start_tick) begin
                    state_d     = ST_SERVE_WAIT;
                    frame_cnt_d = 8'd0;
                end
            end
            ST_SERVE_WAIT: begin
                if (vsync_tick) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    if (frame_cnt_d == 8'(c_SERVE_FRAMES)) state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (p1_miss) begin
                    serve_dir_d = 1'b0;
                    state_d     = ST_POINT;
                end else if (p2_miss) begin
                    serve_dir_d = 1'b1;
                    state_d     = ST_POINT;
                end
            end
            ST_POINT: begin
                // Serve direction was just pointed at the loser, so it names the earner.
                if (!serve_dir_q) begin
                    p2_score_d = sat_inc(p2_score_q);
                    if (p2_score_d == 4'(c_SCORE_LIMIT)) winner_d = WIN_P2;
                end else begin
                    p1_score_d = sat_inc(p1_score_q);
                    if (p1_score_d == 4'(c_SCORE_LIMIT)) winner_d = WIN_P1;
                end
                if (winner_d != WIN_NONE) begin
                    state_d = ST_GAME_OVER;
                end else begin
                    frame_cnt_d = 8'd0;
                    state_d     = ST_SERVE_WAIT;
                end
            end
            ST_GAME_OVER: begin
                if (start_tick) begin
                    p1_score_d  = 4'd0;
                    p2_score_d  = 4'd0;
                    winner_d    = WIN_NONE;
                    serve_dir_d = 1'b1;
                    frame_cnt_d = 8'd0;
                    state_d     = ST_SERVE_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= 8'd0;
            p1_score_q    <= 4'd0;
            p2_score_q    <= 4'd0;
            serve_dir_q   <= 1'b1;
            winner_q      <= WIN_NONE;
            game_active_q <= 1'b0;
            ball_reset_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            game_active_q <= (state_d == ST_RUNNING);
            ball_reset_q  <= (state_d != ST_RUNNING);
        end
    end

    assign o_Game_Active = game_active_q;
    assign o_Ball_Reset  = ball_reset_q;
    assign o_Serve_Dir   = serve_dir_q;
    assign o_P1_Score    = p1_score_q;
    assign o_P2_Score    = p2_score_q;
    assign o_Winner      = winner_q;
    assign o_State       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scenario bench for pong_match_ctrl with a short serve delay; expected
// outputs are queued as stimulus is applied and compared once the DUT settles.
module tb_pong_match_ctrl;

    localparam int SERVE = 3;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_VSync = 1'b0;
    logic       i_Game_Start = 1'b0;
    logic [5:0] i_Ball_X = 6'd20;
    logic [5:0] i_Ball_Y = 6'd15;
    logic [5:0] i_Paddle_Y_P1 = 6'd12;
    logic [5:0] i_Paddle_Y_P2 = 6'd12;
    logic       o_Game_Active, o_Ball_Reset, o_Serve_Dir;
    logic [3:0] o_P1_Score, o_P2_Score;
    logic [1:0] o_Winner;
    logic [2:0] o_State;

    pong_match_ctrl #(
        .c_GAME_WIDTH    (40),
        .c_PADDLE_HEIGHT (6),
        .c_SCORE_LIMIT   (9),
        .c_SERVE_FRAMES  (SERVE)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_VSync       (i_VSync),
        .i_Game_Start  (i_Game_Start),
        .i_Ball_X      (i_Ball_X),
        .i_Ball_Y      (i_Ball_Y),
        .i_Paddle_Y_P1 (i_Paddle_Y_P1),
        .i_Paddle_Y_P2 (i_Paddle_Y_P2),
        .o_Game_Active (o_Game_Active),
        .o_Ball_Reset  (o_Ball_Reset),
        .o_Serve_Dir   (o_Serve_Dir),
        .o_P1_Score    (o_P1_Score),
        .o_P2_Score    (o_P2_Score),
        .o_Winner      (o_Winner),
        .o_State       (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    // {state, p1, p2, dir, winner, active, ball_reset}
    logic [15:0] obs;
    assign obs = {o_State, o_P1_Score, o_P2_Score, o_Serve_Dir, o_Winner,
                  o_Game_Active, o_Ball_Reset};

    logic [15:0] sb_q[$];
    logic [15:0] exp_v;
    int checks = 0;
    int errors = 0;

    logic [3:0] m_p1 = 4'd0;
    logic [3:0] m_p2 = 4'd0;
    logic       m_dir = 1'b1;
    logic [1:0] m_win = 2'b00;

    function automatic logic [15:0] mk(input logic [2:0] st);
        return {st, m_p1, m_p2, m_dir, m_win, st == 3'd2, st != 3'd2};
    endfunction

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic vs_pulse();
        i_VSync = 1'b1;
        step();
        i_VSync = 1'b0;
        step();
    endtask

    task automatic serve();
        for (int i = 0; i < SERVE; i++) vs_pulse();
    endtask

    // Ball leaves via the right goal above P2's paddle (rows 1..6); P1 scores.
    task automatic p2_miss_point();
        i_Ball_X = 6'd39; i_Ball_Y = 6'd0; i_Paddle_Y_P2 = 6'd1;
        step();
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        step();
    endtask

    task automatic test_reset();
        i_Rst_L = 1'b0;
        step();
        sb_q.push_back(mk(3'd0));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset: got %h expected %h", obs, exp_v); end
        i_Rst_L = 1'b1;
        step();
    endtask

    task automatic test_serve_timing();
        i_Game_Start = 1'b1;
        step();
        sb_q.push_back(mk(3'd1));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL start_edge: got %h expected %h", obs, exp_v); end
        for (int i = 1; i <= SERVE; i++) begin
            vs_pulse();
            sb_q.push_back(mk(i == SERVE ? 3'd2 : 3'd1));
            exp_v = sb_q.pop_front(); checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL serve_pulse%0d: got %h expected %h", i, obs, exp_v); end
        end
        // Start still held: must not re-trigger anything.
        step();
        sb_q.push_back(mk(3'd2));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL start_held: got %h expected %h", obs, exp_v); end
        i_Game_Start = 1'b0;
    endtask

    task automatic test_p1_paddle_edge();
        i_Ball_X = 6'd0; i_Ball_Y = 6'd7; i_Paddle_Y_P1 = 6'd2;
        step();
        sb_q.push_back(mk(3'd2));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL edge_row_hit: got %h expected %h", obs, exp_v); end
        i_Ball_Y = 6'd8;
        step();
        m_dir = 1'b0;
        sb_q.push_back(mk(3'd3));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL edge_row_miss: got %h expected %h", obs, exp_v); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        step();
        m_p2 = m_p2 + 4'd1;
        sb_q.push_back(mk(3'd1));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL p2_scored: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_p1_miss_below();
        serve();
        i_Ball_X = 6'd0; i_Ball_Y = 6'd10; i_Paddle_Y_P1 = 6'd2;
        step();
        sb_q.push_back(mk(3'd3));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL p1_miss_point: got %h expected %h", obs, exp_v); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        step();
        m_p2 = m_p2 + 4'd1;
        sb_q.push_back(mk(3'd1));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL p1_miss_score: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_p2_miss();
        serve();
        i_Ball_X = 6'd39; i_Ball_Y = 6'd0; i_Paddle_Y_P2 = 6'd1;
        step();
        m_dir = 1'b1;
        sb_q.push_back(mk(3'd3));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL p2_miss_point: got %h expected %h", obs, exp_v); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        step();
        m_p1 = m_p1 + 4'd1;
        sb_q.push_back(mk(3'd1));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL p1_scored: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_match_win();
        while (m_p1 < 4'd8) begin
            serve();
            p2_miss_point();
            m_p1 = m_p1 + 4'd1;
        end
        sb_q.push_back(mk(3'd1));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL p1_at_8: got %h expected %h", obs, exp_v); end
        serve();
        p2_miss_point();
        m_p1  = 4'd9;
        m_win = 2'b01;
        sb_q.push_back(mk(3'd4));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL game_over: got %h expected %h", obs, exp_v); end
        for (int i = 0; i < 4; i++) vs_pulse();
        sb_q.push_back(mk(3'd4));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL vsync_in_game_over: got %h expected %h", obs, exp_v); end
        i_Game_Start = 1'b1;
        step();
        i_Game_Start = 1'b0;
        m_p1 = 4'd0; m_p2 = 4'd0; m_win = 2'b00; m_dir = 1'b1;
        sb_q.push_back(mk(3'd1));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL restart: got %h expected %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_running();
        for (int i = 0; i < 3; i++) begin
            serve();
            p2_miss_point();
            m_p1 = m_p1 + 4'd1;
        end
        serve();
        sb_q.push_back(mk(3'd2));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL running_p1_3: got %h expected %h", obs, exp_v); end
        i_Ball_X = 6'd0; i_Ball_Y = 6'd40; i_Paddle_Y_P1 = 6'd2;
        i_Rst_L = 1'b0;
        step();
        m_p1 = 4'd0; m_p2 = 4'd0; m_win = 2'b00; m_dir = 1'b1;
        sb_q.push_back(mk(3'd0));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL reset_mid: got %h expected %h", obs, exp_v); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        i_Rst_L = 1'b1;
        step();
        sb_q.push_back(mk(3'd0));
        exp_v = sb_q.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL after_reset_idle: got %h expected %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_serve_timing();
        test_p1_paddle_edge();
        test_p1_miss_below();
        test_p2_miss();
        test_match_win();
        test_reset_mid_running();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
